// File: rtl/spi_slave_regs.sv
//------------------------------------------------------------------------------
// spi_slave_regs : SPI mode-0 responder with an oversampled pin interface and
//                  a 2^ADDR_W x 8 register bank (read-only ID at RO_ADDR).
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave_regs #(
    parameter int                ADDR_W  = 7,
    parameter logic [ADDR_W-1:0] RO_ADDR = 7'h75,
    parameter logic [7:0]        RO_VAL  = 8'h68
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              SCLK_i,
    input  logic              SS_ni,
    input  logic              MOSI_i,
    output logic              MISO_o,
    output logic              MISO_oe_o,
    input  logic [ADDR_W-1:0] reg_addr_i,
    output logic [7:0]        reg_rdata_o,
    output logic              wr_strobe_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sclk_q, ss_q;
    logic [1:0]        mosi_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic              bank_we;
    logic [7:0]        bank_q [DEPTH];

    logic              w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic [7:0]        w_rx_next, w_spi_rdata;

    // SS chain resets low so a select already asserted at reset release
    // never looks like a falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK_i};
            ss_q   <= {ss_q[1:0], SS_ni};
            mosi_q <= {mosi_q[0], MOSI_i};
        end
    end

    assign w_sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign w_sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign w_ss_rise   = ss_q[1] & ~ss_q[2];
    assign w_ss_fall   = ~ss_q[1] & ss_q[2];
    assign w_rx_next   = {rx_q[6:0], mosi_q[1]};
    assign w_spi_rdata = (addr_q == RO_ADDR) ? RO_VAL : bank_q[addr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        bank_we     = 1'b0;

        if (w_ss_rise) begin
            state_d     = S_IDLE;
            frame_err_d = (bit_cnt_q != 3'd0);
            bit_cnt_d   = 3'd0;
            tx_d        = 8'h00;
        end else if (w_ss_fall) begin
            if (state_q == S_IDLE) begin
                state_d   = S_CMD;
                bit_cnt_d = 3'd0;
                tx_d      = 8'h00;
            end
        end else if (state_q != S_IDLE) begin
            if (w_sclk_rise) begin
                rx_d      = w_rx_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == S_CMD) begin
                        addr_d  = w_rx_next[ADDR_W-1:0];
                        state_d = w_rx_next[7] ? S_RD : S_WR;
                    end else if (state_q == S_WR) begin
                        if (addr_q != RO_ADDR) begin
                            bank_we     = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = w_rx_next;
                        end
                        addr_d = addr_q + 1'b1;
                    end
                end
            end else if (w_sclk_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    if (state_q == S_RD) begin
                        tx_d   = w_spi_rdata;
                        addr_d = addr_q + 1'b1;
                    end else begin
                        tx_d = 8'h00;
                    end
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else if (bank_we) begin
            bank_q[addr_q] <= w_rx_next;
        end
    end

    assign reg_rdata_o = (reg_addr_i == RO_ADDR) ? RO_VAL : bank_q[reg_addr_i];
    assign MISO_o      = tx_q[7];
    assign busy_o      = (state_q != S_IDLE);
    assign MISO_oe_o   = busy_o;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_err_o = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
//------------------------------------------------------------------------------
// tb_spi_slave_regs : scoreboard-based bench driving SPI frames into spi_slave_regs.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_regs;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, wr_strobe, busy, frame_err;
    logic [6:0] reg_addr = 7'h00;
    logic [7:0] reg_rdata, wr_data;
    logic [6:0] wr_addr;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    logic [14:0] exp_q [$];

    always #5 clk = ~clk;

    spi_slave_regs dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .SCLK_i      (sclk),
        .SS_ni       (ss_n),
        .MOSI_i      (mosi),
        .MISO_o      (miso),
        .MISO_oe_o   (miso_oe),
        .reg_addr_i  (reg_addr),
        .reg_rdata_o (reg_rdata),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    // Strobe scoreboard and frame-error pulse counter.
    always @(negedge clk) begin
        if (rst_n && frame_err) ferr_cnt++;
        if (rst_n && wr_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got addr=%h data=%h, expected no strobe", wr_addr, wr_data);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL strobe_value: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, e[14:8], e[7:0]);
                end
            end
        end
    end

    task automatic ss_begin;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_end;
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Shifts nbits of tx MSB first; rx collects MISO as seen just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_strobe: %0d strobes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        logic [7:0] rx;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ss_begin();
        spi_bits(8'h05, 8, rx);
        exp_q.push_back({7'h05, 8'h77});
        spi_bits(8'h77, 8, rx);
        spi_bits(8'hAA, 4, rx);
        reg_addr = 7'h05; #1;
        checks++;
        if (reg_rdata !== 8'h77) begin errors++; $display("FAIL pre_reset_write: got %h expected 77", reg_rdata); end
        rst_n = 1'b0; #1;
        checks++;
        if ({miso, miso_oe, busy, wr_strobe, frame_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got miso/oe/busy/strobe/ferr=%b expected 00000",
                               {miso, miso_oe, busy, wr_strobe, frame_err});
        end
        checks++;
        if (wr_addr !== 7'h00 || wr_data !== 8'h00) begin
            errors++; $display("FAIL reset_wr_bus: got addr=%h data=%h expected 00/00", wr_addr, wr_data);
        end
        checks++;
        if (reg_rdata !== 8'h00) begin errors++; $display("FAIL reset_bank_05: got %h expected 00", reg_rdata); end
        reg_addr = 7'h10; #1;
        checks++;
        if (reg_rdata !== 8'h00) begin errors++; $display("FAIL reset_bank_10: got %h expected 00", reg_rdata); end
        reg_addr = 7'h75; #1;
        checks++;
        if (reg_rdata !== 8'h68) begin errors++; $display("FAIL reset_id: got %h expected 68", reg_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // SS is still low here: that must not start a frame.
        spi_bits(8'h10, 8, rx);
        spi_bits(8'hC3, 8, rx);
        checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            errors++; $display("FAIL reset_no_frame: got busy=%b oe=%b expected 0/0", busy, miso_oe);
        end
        ss_end();
        check_drained("reset");
    endtask

    task automatic test_burst_write;
        logic [7:0] rx;
        logic [7:0] tx [3] = '{8'h10, 8'hA5, 8'h3C};
        checks++;
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL wr_oe_idle: got %b expected 0", miso_oe); end
        ss_begin();
        exp_q.push_back({7'h10, 8'hA5});
        exp_q.push_back({7'h11, 8'h3C});
        for (int i = 0; i < 3; i++) begin
            spi_bits(tx[i], 8, rx);
            checks++;
            if (rx !== 8'h00) begin errors++; $display("FAIL wr_miso_byte%0d: got %h expected 00", i, rx); end
        end
        ss_end();
        check_drained("burst_write");
        reg_addr = 7'h10; #1;
        checks++;
        if (reg_rdata !== 8'hA5) begin errors++; $display("FAIL wr_local_10: got %h expected a5", reg_rdata); end
        reg_addr = 7'h11; #1;
        checks++;
        if (reg_rdata !== 8'h3C) begin errors++; $display("FAIL wr_local_11: got %h expected 3c", reg_rdata); end
    endtask

    task automatic read_frame(input string name, input logic [7:0] cmd, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] rx;
        logic [7:0] exp_rx [3];
        exp_rx = '{8'h00, e0, e1};
        ss_begin();
        checks++;
        if (miso_oe !== 1'b1) begin errors++; $display("FAIL %s_oe_active: got %b expected 1", name, miso_oe); end
        spi_bits(cmd, 8, rx);
        checks++;
        if (rx !== exp_rx[0]) begin errors++; $display("FAIL %s_cmd_miso: got %h expected %h", name, rx, exp_rx[0]); end
        for (int i = 1; i < 3; i++) begin
            spi_bits(8'h00, 8, rx);
            checks++;
            if (rx !== exp_rx[i]) begin errors++; $display("FAIL %s_data%0d: got %h expected %h", name, i, rx, exp_rx[i]); end
        end
        ss_end();
        checks++;
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL %s_oe_after: got %b expected 0", name, miso_oe); end
        check_drained(name);
    endtask

    task automatic test_burst_read;
        read_frame("burst_read", 8'h90, 8'hA5, 8'h3C);
    endtask

    task automatic test_addr_wrap;
        logic [7:0] rx;
        ss_begin();
        exp_q.push_back({7'h7F, 8'h11});
        exp_q.push_back({7'h00, 8'h22});
        spi_bits(8'h7F, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        ss_end();
        check_drained("wrap_write");
        reg_addr = 7'h7F; #1;
        checks++;
        if (reg_rdata !== 8'h11) begin errors++; $display("FAIL wrap_local_7f: got %h expected 11", reg_rdata); end
        reg_addr = 7'h00; #1;
        checks++;
        if (reg_rdata !== 8'h22) begin errors++; $display("FAIL wrap_local_00: got %h expected 22", reg_rdata); end
        read_frame("wrap_read", 8'hFF, 8'h11, 8'h22);
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        int ferr0;
        ferr0 = ferr_cnt;
        ss_begin();
        spi_bits(8'h30, 8, rx);
        spi_bits(8'h99, 5, rx);
        ss_end();
        checks++;
        if (ferr_cnt - ferr0 != 1) begin errors++; $display("FAIL abort_frame_err: got %0d pulse cycles expected 1", ferr_cnt - ferr0); end
        reg_addr = 7'h30; #1;
        checks++;
        if (reg_rdata !== 8'h00) begin errors++; $display("FAIL abort_no_write: got %h expected 00", reg_rdata); end
        ss_begin();
        exp_q.push_back({7'h20, 8'h55});
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h55, 8, rx);
        ss_end();
        check_drained("abort_next");
        checks++;
        if (ferr_cnt - ferr0 != 1) begin errors++; $display("FAIL abort_next_ferr: got %0d pulse cycles expected 1", ferr_cnt - ferr0); end
        reg_addr = 7'h20; #1;
        checks++;
        if (reg_rdata !== 8'h55) begin errors++; $display("FAIL abort_next_local: got %h expected 55", reg_rdata); end
    endtask

    task automatic test_read_only;
        logic [7:0] rx;
        ss_begin();
        exp_q.push_back({7'h76, 8'h42});
        spi_bits(8'h75, 8, rx);
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h42, 8, rx);
        ss_end();
        check_drained("ro_write");
        reg_addr = 7'h75; #1;
        checks++;
        if (reg_rdata !== 8'h68) begin errors++; $display("FAIL ro_local: got %h expected 68", reg_rdata); end
        read_frame("ro_read", 8'hF5, 8'h68, 8'h42);
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_burst_read();
        test_addr_wrap();
        test_abort();
        test_read_only();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode 0 (CPOL=0, CPHA=0) responder with an internal 8-bit register bank, acting as the peripheral end of the `spi_master` bus. It models an MPU6000-style sensor target for master-side bring-up and verification. It also serves as a reusable slave for board-to-board links. The SPI pins are oversampled on the system clock. A local read port and a write-event port expose the register bank to on-chip logic.

## Interface
- `ADDR_W`, 7: register address width; the bank holds 2^ADDR_W bytes.
- `RO_ADDR`, 7'h75: address of the read-only ID register.
- `RO_VAL`, 8'h68: value returned at `RO_ADDR`.

- `clk_i`  in  1  system clock. One clock domain only; reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `SCLK_i`  in  1  SPI serial clock from the master, asynchronous to `clk_i`.
- `SS_ni`  in  1  slave select, active low, asynchronous.
- `MOSI_i`  in  1  master-out data, asynchronous.
- `MISO_o`  out  1  slave-out data.
- `MISO_oe_o`  out  1  MISO output enable. The top level tristates the pad to Z when this is 0.
- `reg_addr_i`  in  ADDR_W  local read address.
- `reg_rdata_o`  out  8  combinational read of the bank at `reg_addr_i`.
- `wr_strobe_o`  out  1  one-cycle pulse when an SPI write commits to the bank.
- `wr_addr_o`  out  ADDR_W  address of the committed write; valid while the strobe is high.
- `wr_data_o`  out  8  data of the committed write; valid while the strobe is high.
- `busy_o`  out  1  frame in progress (synchronized SS active).
- `frame_err_o`  out  1  one-cycle pulse when SS deasserts with a partial byte received.

## Operation
- **Input synchronization:** `SCLK_i`, `SS_ni` and `MOSI_i` each pass through a 2-FF synchronizer. One further register provides rise/fall detection of SCLK and SS.
- **Frame format:** first byte is the command. Bit 7 = 1 selects read, 0 selects write; bits [ADDR_W-1:0] give the start address (MSB first). All following bytes are data. The address auto-increments per data byte and wraps modulo 2^ADDR_W.
- **FSM states:** IDLE, CMD, RD, WR.
  - IDLE → CMD on the SS falling edge. `bit_cnt` clears to 0 and `tx_shift` loads 0x00.
  - CMD → RD or WR after the 8th SCLK rise, according to command bit 7. The address register loads from the command byte.
  - Any state → IDLE on the SS rising edge. The partial byte is discarded and no write occurs. `frame_err_o` pulses if `bit_cnt != 0`.
- **SCLK rise:** `rx_shift <= {rx_shift[6:0], MOSI}` and `bit_cnt` increments (3 bits, wraps 7→0). A byte completes when `bit_cnt` wraps.
- **Byte completion in WR:**
  - Normal address: the bank is written at `addr`, `wr_strobe_o` pulses with `wr_addr_o`/`wr_data_o`, and `addr` increments.
  - `addr == RO_ADDR`: no write and no strobe, but `addr` still increments.
- **SCLK fall:**
  - If `bit_cnt == 0` and the state is RD, `tx_shift` loads `bank[addr]` (with `RO_VAL` substituted at `RO_ADDR`) and `addr` increments.
  - If `bit_cnt == 0` in CMD or WR, `tx_shift` loads 0x00.
  - Otherwise `tx_shift <= tx_shift << 1`.
- **MISO:** `MISO_o = tx_shift[7]`, so MISO reads 0 throughout the command byte and all write bytes.
- **Output enable:** `MISO_oe_o = busy_o`.
- **Register bank:** 2^ADDR_W × 8 flops, reset to 0x00. `RO_ADDR` is not stored; it always reads `RO_VAL`.
- **Local/SPI collision:** a local read of an address in the same cycle as its SPI write returns the old value; the new value appears on the next cycle.

## Timing
- **Reset values:**
  - `MISO_o` 0, `MISO_oe_o` 0, `busy_o` 0.
  - `wr_strobe_o` 0, `wr_addr_o` 0, `wr_data_o` 0, `frame_err_o` 0.
  - FSM in IDLE; bank all 0x00.
  - Reset asserted mid-frame aborts the frame immediately with no strobe. After release the block waits for a new SS falling edge; an SS that is already low is not treated as a frame start.
- **Pin-to-action latency:** 3 `clk_i` cycles from any SCLK/SS pin edge to the resulting action. `MISO_o` changes 3–4 cycles after the SCLK falling pin edge.
- **`wr_strobe_o`:** asserts 3 cycles after the 8th SCLK rise of the data byte.
- **Clock ratio:** requires f_clk ≥ 8 × f_SCLK, i.e. each SCLK phase ≥ 4 `clk_i` cycles. The master must hold SS low ≥ 4 cycles before the first SCLK rise.
- **Simultaneous events:** SCLK and SS edges detected in the same cycle resolve with SS taking priority.

## Test plan
- **Reset:** assert `rst_ni`=0 mid-frame → all outputs at reset values. `reg_rdata_o` = 0x00 at address 0x10 and 0x68 at address 0x75.
- **Burst write:** SS low, send 0x10, 0xA5, 0x3C, SS high → two strobes, (0x10, 0xA5) then (0x11, 0x3C). Local reads confirm both. MISO = 0 throughout.
- **Burst read:** send 0x90 plus two dummy bytes after the burst-write test → MISO returns 0x00 during the command byte, then 0xA5, then 0x3C (MSB first, valid on SCLK rise). `MISO_oe_o` is high only while SS is low.
- **Address wrap:** write command 0x7F with data 0x11, 0x22 → bank[0x7F] = 0x11 and bank[0x00] = 0x22. A read burst from 0x7F returns 0x11, 0x22.
- **Abort:** SS high after 5 bits of a data byte → no strobe and one `frame_err_o` pulse. The next frame (write 0x20, 0x55) commits normally.
- **Read-only ID:** write 0x75 with 0xFF → no strobe. A read of 0x75 over SPI and over the local port returns 0x68.
